// File: rtl/avmm_mem_tester_pkg.sv
// Shared types and constants for the Avalon-MM memory tester.
package avmm_mem_tester_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdReq,
    StRdWait,
    StFin
  } state_e;

  localparam logic [1:0] MODE_FILL   = 2'd0;
  localparam logic [1:0] MODE_VERIFY = 2'd1;
  localparam logic [1:0] MODE_BOTH   = 2'd2;

  // Galois LFSR feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/avmm_pattern_gen.sv
// Test pattern source P(i): seed + i by default, a 32-bit Galois LFSR when MEMTEST_LFSR_EN is
// defined. load restarts the sequence at P(0); advance steps to the next word.
module avmm_pattern_gen #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic [DATA_W-1:0] pattern_o
);

`ifdef MEMTEST_LFSR_EN
  import avmm_mem_tester_pkg::*;

  logic [31:0] lfsr_q, lfsr_d, seed32;

  always_comb begin
    seed32 = 32'(seed_i);
    lfsr_d = lfsr_q;
    if (load_i) begin
      // An all-zero state would lock the LFSR.
      lfsr_d = (seed32 == '0) ? 32'd1 : seed32;
    end else if (advance_i) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= 32'd1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign pattern_o = DATA_W'(lfsr_q);
`else
  logic [DATA_W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = seed_i;
    end else if (advance_i) begin
      val_d = val_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign pattern_o = val_q;
`endif

endmodule

// File: rtl/avmm_mem_tester.sv
// Avalon-MM memory tester: fills a word range with P(i), reads it back and counts mismatches.
// Define MEMTEST_LFSR_EN to use an LFSR pattern instead of seed + i.
module avmm_mem_tester
  import avmm_mem_tester_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     base,
  input  logic [ADDR_W:0]       length,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest
);

  localparam logic [ADDR_W:0] MaxLen  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]      LatLast = 3'(READ_LATENCY);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, addr;
  logic [ADDR_W:0]   len_q, len_in, idx_q, idx_d;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q, pat_seed, pattern;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic [2:0]        lat_q, lat_d;
  logic              pat_load, pat_adv, last_word;

  // Any length with the top bit set is at least the whole address space.
  assign len_in    = length[ADDR_W] ? MaxLen : length;
  assign addr      = base_q + idx_q[ADDR_W-1:0];
  assign last_word = (idx_q + 1'b1) == len_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    lat_d    = lat_q;
    pat_load = 1'b0;
    pat_adv  = 1'b0;
    pat_seed = seed_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_load = 1'b1;
          pat_seed = seed;
          idx_d    = '0;
          err_d    = '0;
          ferr_d   = '0;
          if (len_in == '0) begin
            state_d = StFin;
          end else if (mode == MODE_VERIFY) begin
            state_d = StRdReq;
          end else begin
            state_d = StWr;
          end
        end
      end
      StWr: begin
        if (!avm_waitrequest) begin
          pat_adv = 1'b1;
          idx_d   = idx_q + 1'b1;
          if (last_word) begin
            idx_d = '0;
            if (mode_q == MODE_FILL) begin
              state_d = StFin;
            end else begin
              // Restart the pattern so the verify pass sees the same sequence.
              pat_load = 1'b1;
              state_d  = StRdReq;
            end
          end
        end
      end
      StRdReq: begin
        if (!avm_waitrequest) begin
          lat_d   = 3'd1;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (lat_q == LatLast) begin
          if (avm_readdata != pattern) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) ferr_d = addr;
          end
          pat_adv = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = last_word ? StFin : StRdReq;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      base_q  <= '0;
      len_q   <= '0;
      mode_q  <= MODE_FILL;
      seed_q  <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      lat_q   <= lat_d;
      if (state_q == StIdle && start) begin
        base_q <= base;
        len_q  <= len_in;
        mode_q <= mode;
        seed_q <= seed;
      end
    end
  end

  avmm_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (pat_load),
    .advance_i (pat_adv),
    .seed_i    (pat_seed),
    .pattern_o (pattern)
  );

  assign busy           = (state_q == StWr) || (state_q == StRdReq) || (state_q == StRdWait);
  assign done           = (state_q == StFin);
  assign avm_write      = (state_q == StWr);
  assign avm_read       = (state_q == StRdReq);
  assign avm_address    = (avm_write || avm_read) ? addr : '0;
  assign avm_writedata  = avm_write ? pattern : '0;
  assign avm_byteenable = '1;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_avmm_mem_tester.sv
// Bench for avmm_mem_tester: RAM slave model with optional stalls, reference model producing
// expected bus transactions and results, and a monitor that scores whatever the DUT emits.
module tb_avmm_mem_tester;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned RL = 1;
  localparam int unsigned NW = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    mode;
  logic [AW-1:0] base;
  logic [AW:0]   length;
  logic [DW-1:0] seed;
  logic          busy, done;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr, avm_address;
  logic          avm_write, avm_read;
  logic [DW-1:0] avm_writedata, avm_readdata;
  logic [DW/8-1:0] avm_byteenable;
  logic          avm_waitrequest;

  always #5 clk = ~clk;

  avmm_mem_tester #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .READ_LATENCY (RL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mode            (mode),
    .base            (base),
    .length          (length),
    .seed            (seed),
    .busy            (busy),
    .done            (done),
    .err_count       (err_count),
    .first_err_addr  (first_err_addr),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_read        (avm_read),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct packed {logic [AW:0] err; logic [AW-1:0] addr;} res_t;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  res_t          exp_res[$];
  int            wr_cyc[$], rd_cyc[$];

  logic [DW-1:0] ram     [0:NW-1];
  logic [DW-1:0] ref_mem [0:NW-1];
  logic [DW-1:0] fault   [0:NW-1];

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_base = 0, start_cyc = 0, last_n = 0;
  bit stall_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] p_first(input logic [DW-1:0] s);
`ifdef MEMTEST_LFSR_EN
    return (s == '0) ? 1 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [DW-1:0] p_next(input logic [DW-1:0] p);
`ifdef MEMTEST_LFSR_EN
    return p[0] ? ((p >> 1) ^ 32'h8020_0003) : (p >> 1);
`else
    return p + 1;
`endif
  endfunction

  // RAM slave: 0..3 stall cycles per request when stall_en, readdata valid RL cycle after accept.
  int            stall_left = 0;
  bit            in_req = 1'b0, rd_pend = 1'b0;
  logic [AW-1:0] rd_addr;
  always @(negedge clk) begin
    avm_readdata = rd_pend ? (ram[rd_addr] ^ fault[rd_addr]) : DW'($urandom);
    rd_pend = 1'b0;
    if (reset) begin
      avm_waitrequest = 1'b0;
      in_req = 1'b0;
    end else if (avm_write || avm_read) begin
      if (!in_req) begin
        in_req = 1'b1;
        stall_left = stall_en ? int'($urandom_range(0, 3)) : 0;
      end
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        in_req = 1'b0;
        if (avm_write) ram[avm_address] = avm_writedata;
        else begin
          rd_pend = 1'b1;
          rd_addr = avm_address;
        end
      end
    end else begin
      avm_waitrequest = 1'b0;
      in_req = 1'b0;
    end
  end

  // Monitor / scoreboard.
  bit            prev_stall = 1'b0, prev_done = 1'b0;
  logic [47:0]   prev_req;
  wr_t           mon_w;
  res_t          mon_r;
  logic [AW-1:0] mon_a;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      prev_stall = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {avm_write, avm_read, avm_address, avm_writedata},
                            prev_req);
      if (avm_write || avm_read) begin
        check("byteenable", avm_byteenable, 64'hF);
        if (avm_write && avm_read) check("rd_wr_exclusive", 1, 0);
      end
      if ((avm_write || avm_read) && !avm_waitrequest) begin
        if (avm_write) begin
          wr_cyc.push_back(cyc);
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                     avm_address, avm_writedata);
          end else begin
            mon_w = exp_wr.pop_front();
            check("wr_addr", avm_address, mon_w.addr);
            check("wr_data", avm_writedata, mon_w.data);
          end
        end else begin
          rd_cyc.push_back(cyc);
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: addr 0x%0h, none expected", avm_address);
          end else begin
            mon_a = exp_rd.pop_front();
            check("rd_addr", avm_address, mon_a);
          end
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_low_at_done", busy, 0);
        check("done_single_cycle", prev_done, 0);
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: err_count %0d, none expected", err_count);
        end else begin
          mon_r = exp_res.pop_front();
          check("err_count", err_count, mon_r.err);
          check("first_err_addr", first_err_addr, mon_r.addr);
        end
      end
      prev_done = done;
      prev_stall = (avm_write || avm_read) && avm_waitrequest;
      prev_req = {avm_write, avm_read, avm_address, avm_writedata};
    end
  end

  // Reference model: push the expected transactions and result, then pulse start.
  task automatic issue(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW:0] len,
                       input logic [DW-1:0] s);
    int n, errs;
    logic [DW-1:0] p;
    logic [AW-1:0] a, fa;
    res_t r;
    wr_t w;
    n = (len > NW) ? NW : int'(len);
    errs = 0;
    fa = '0;
    if (m != 2'd1) begin
      p = p_first(s);
      for (int i = 0; i < n; i++) begin
        a = AW'(b + i);
        w.addr = a; w.data = p;
        exp_wr.push_back(w);
        ref_mem[a] = p;
        p = p_next(p);
      end
    end
    if (m != 2'd0) begin
      p = p_first(s);
      for (int i = 0; i < n; i++) begin
        a = AW'(b + i);
        exp_rd.push_back(a);
        if ((ref_mem[a] ^ fault[a]) != p) begin
          if (errs == 0) fa = a;
          errs++;
        end
        p = p_next(p);
      end
    end
    r.err = (AW+1)'(errs);
    r.addr = fa;
    exp_res.push_back(r);
    last_n = n;
    done_base = done_cnt;
    @(negedge clk);
    mode = m; base = b; length = len; seed = s; start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) check("len0_done_next_cycle", done, 1);
    else check("busy_rise", busy, 1);
  endtask

  task automatic wait_done();
    int budget;
    budget = last_n * 2 * (RL + 6) + 40;
    while (done_cnt == done_base && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (done_cnt == done_base) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within cycle budget (cycle %0d)", cyc);
    end
    repeat (2) @(negedge clk);
    #2;
    check("done_count", done_cnt - done_base, 1);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
  endtask

  int n0w, n0r, budget;

  initial begin
    for (int i = 0; i < NW; i++) begin
      ram[i] = '0; ref_mem[i] = '0; fault[i] = '0;
    end
    reset = 1'b1; start = 1'b0; mode = '0; base = '0; length = '0; seed = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", avm_write, 0);
    check("rst_read", avm_read, 0);
    check("rst_addr", avm_address, 0);
    check("rst_wdata", avm_writedata, 0);
    check("rst_err", err_count, 0);
    check("rst_ferr", first_err_addr, 0);
    reset = 1'b0;

    // Fill only, no stalls: four back-to-back writes, no reads.
    n0w = wr_cyc.size(); n0r = rd_cyc.size();
    issue(2'd0, 14'h10, 15'd4, 32'hA0);
    wait_done();
    check("t1_writes", wr_cyc.size() - n0w, 4);
    check("t1_reads", rd_cyc.size() - n0r, 0);
    if (wr_cyc.size() >= n0w + 4) begin
      check("t1_first_wr_cycle", wr_cyc[n0w], start_cyc + 1);
      check("t1_last_wr_cycle", wr_cyc[n0w+3], start_cyc + 4);
    end

    // Fill then verify, ideal RAM.
    n0w = wr_cyc.size(); n0r = rd_cyc.size();
    issue(2'd2, 14'h40, 15'd8, $urandom);
    wait_done();
    check("t2_writes", wr_cyc.size() - n0w, 8);
    check("t2_reads", rd_cyc.size() - n0r, 8);
    if (rd_cyc.size() >= n0r + 2) check("t2_read_spacing", rd_cyc[n0r+1] - rd_cyc[n0r], RL + 1);

    // Injected faults at 0x13 and 0x15.
    fault['h13] = 32'h0000_0100;
    fault['h15] = 32'h8000_0000;
    issue(2'd2, 14'h10, 15'd8, 32'h55);
    wait_done();
    check("t3_err_count", err_count, 2);
    check("t3_first_err_addr", first_err_addr, 14'h13);
    fault['h15] = '0;

    // Boundaries: zero length and address wrap.
    n0w = wr_cyc.size(); n0r = rd_cyc.size();
    issue(2'd2, 14'h20, 15'd0, 32'h1);
    wait_done();
    check("t5_len0_no_writes", wr_cyc.size() - n0w, 0);
    check("t5_len0_no_reads", rd_cyc.size() - n0r, 0);
    issue(2'd3, 14'h3FFE, 15'd4, $urandom);
    wait_done();

    // Random stalls and random commands, with a couple of faults in the exercised region.
    stall_en = 1'b1;
    fault[$urandom_range(0, 63)] = 32'h0000_0001;
    fault[$urandom_range(0, 63)] = 32'h0010_0000;
    for (int k = 0; k < 10; k++) begin
      issue(2'($urandom_range(0, 3)), 14'($urandom_range(0, 63)),
            15'($urandom_range(0, 24)), $urandom);
      wait_done();
    end
    stall_en = 1'b0;
    for (int i = 0; i < 64; i++) fault[i] = '0;

    // Reset while waiting for read data after one mismatch has been counted.
    fault['h13] = 32'h0000_0100;
    n0r = rd_cyc.size();
    issue(2'd1, 14'h13, 15'd4, 32'h58);
    budget = 60;
    while (rd_cyc.size() < n0r + 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("t6_reached_second_read", rd_cyc.size() >= n0r + 2, 1);
    check("t6_pre_reset_err", err_count, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_read", avm_read, 0);
    check("t6_write", avm_write, 0);
    check("t6_addr", avm_address, 0);
    check("t6_wdata", avm_writedata, 0);
    check("t6_err", err_count, 0);
    check("t6_ferr", first_err_addr, 0);
    exp_wr.delete(); exp_rd.delete(); exp_res.delete();
    reset = 1'b0;
    fault['h13] = '0;
    @(negedge clk);

    // Start pulses while busy must be ignored.
    issue(2'd0, 14'h200, 15'd6, 32'h1234);
    mode = 2'd1; base = 14'h300; length = 15'd3; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("t6_no_restart", busy, 0);

    // Oversized length is clamped to the whole address space.
    n0w = wr_cyc.size();
    issue(2'd0, 14'h0100, 15'h7FFF, 32'hC0DE_0000);
    wait_done();
    check("t7_clamped_writes", wr_cyc.size() - n0w, NW);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
